// File: rtl/ram_port_dma_if.sv
// ram_port_dma_if: command, write-stream, read-stream and RAM-port bundle for ram_port_dma.
// master = the DMA engine side, slave = the environment (command source, streams, RAM).
interface ram_port_dma_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 64,
    parameter int LWIDTH = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [LWIDTH-1:0] cmd_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DWIDTH-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DWIDTH-1:0] rdata;
    logic              done;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_d;
    logic              ram_ce;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_q;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready, ram_q,
        output cmd_ready, wdata_ready, rdata_valid, rdata, done, ram_addr, ram_d, ram_ce, ram_we
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready, ram_q,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, done, ram_addr, ram_d, ram_ce, ram_we
    );
endinterface

// File: rtl/ram_port_dma.sv
// ram_port_dma: burst engine for one RAM bank port. Write bursts take a valid/ready stream,
// read bursts return through a small FIFO; reads are only issued when FIFO space is guaranteed
// for every word already in flight through the fixed-latency RAM pipe.
// Optional macro RAM_DMA_STATS_EN adds saturating access/stall counters (stat_beats_o, stat_stalls_o).
module ram_port_dma #(
    parameter int AWIDTH       = 12,
    parameter int DWIDTH       = 64,
    parameter int LWIDTH       = 12,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ram_port_dma_if.master bus
`ifdef RAM_DMA_STATS_EN
    ,
    output logic [31:0]    stat_beats_o,
    output logic [31:0]    stat_stalls_o
`endif
);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int INFW = $clog2(READ_LATENCY + 2);
    localparam int OCCW = CNTW + 1;
    localparam logic [LWIDTH:0]   BEAT_ONE = 1;
    localparam logic [AWIDTH-1:0] ADDR_ONE = 1;
    localparam logic [PTRW-1:0]   PTR_ONE  = 1;
    localparam logic [CNTW-1:0]   CNT_ONE  = 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

    state_e              state_q;
    logic [AWIDTH-1:0]   addr_q;
    logic [LWIDTH:0]     beats_q;      // one bit wider so cmd_len all-ones means 2^LWIDTH beats
    logic                done_q;
    logic                ram_ce_q;
    logic                ram_we_q;
    logic [AWIDTH-1:0]   ram_addr_q;
    logic [DWIDTH-1:0]   ram_d_q;
    logic [READ_LATENCY:0] rd_pipe_q;  // bit k set: a read was on the RAM port k cycles ago

    logic [DWIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0]     wr_ptr_q;
    logic [PTRW-1:0]     rd_ptr_q;
    logic [CNTW-1:0]     fifo_cnt_q;

    logic [INFW-1:0]     infl_cnt;
    logic [OCCW-1:0]     occ;
    logic                credit_ok;
    logic                rd_issue;
    logic                wr_hs;
    logic                push;
    logic                pop;
    logic                drain_done;

    // Count reads still travelling through the RAM pipe (including the one landing this cycle).
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            infl_cnt = infl_cnt + INFW'(rd_pipe_q[i]);
        end
    end

    assign occ        = OCCW'(fifo_cnt_q) + OCCW'(infl_cnt);
    assign credit_ok  = occ < OCCW'(FIFO_DEPTH);
    assign rd_issue   = (state_q == READ) && (beats_q != '0) && credit_ok;
    assign wr_hs      = (state_q == WRITE) && bus.wdata_valid;
    assign push       = rd_pipe_q[READ_LATENCY];
    assign pop        = (fifo_cnt_q != '0) && bus.rdata_ready;
    assign drain_done = (state_q == DRAIN) && (infl_cnt == '0) &&
                        ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_ONE) && pop));

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.wdata_ready = (state_q == WRITE);
    assign bus.rdata_valid = (fifo_cnt_q != '0);
    assign bus.rdata       = fifo_mem[rd_ptr_q];
    assign bus.done        = done_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_d       = ram_d_q;
    assign bus.ram_ce      = ram_ce_q;
    assign bus.ram_we      = ram_we_q;

    // Burst FSM with registered RAM port, done pulse and read-tracking pipe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            done_q     <= 1'b0;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_d_q    <= '0;
            rd_pipe_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            ram_ce_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            rd_pipe_q <= {rd_pipe_q[READ_LATENCY-1:0], rd_issue};
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q  <= bus.cmd_addr;
                        beats_q <= {1'b0, bus.cmd_len} + BEAT_ONE;
                        state_q <= bus.cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_hs) begin
                        ram_ce_q   <= 1'b1;
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= addr_q;
                        ram_d_q    <= bus.wdata;
                        addr_q     <= addr_q + ADDR_ONE;
                        beats_q    <= beats_q - BEAT_ONE;
                        if (beats_q == BEAT_ONE) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        ram_ce_q   <= 1'b1;
                        ram_addr_q <= addr_q;
                        addr_q     <= addr_q + ADDR_ONE;
                        beats_q    <= beats_q - BEAT_ONE;
                        if (beats_q == BEAT_ONE) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read-return FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage captures RAM data as each read leaves the latency pipe.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.ram_q;
    end

`ifdef RAM_DMA_STATS_EN
    logic [31:0] stat_beats_q;
    logic [31:0] stat_stalls_q;
    logic        stall;

    assign stall = ((state_q == READ) && (beats_q != '0) && !credit_ok) ||
                   ((state_q == WRITE) && !bus.wdata_valid);
    assign stat_beats_o  = stat_beats_q;
    assign stat_stalls_o = stat_stalls_q;

    // Saturating counters of RAM accesses issued and cycles lost to credit or missing data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_beats_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if ((rd_issue || wr_hs) && (stat_beats_q != '1)) stat_beats_q <= stat_beats_q + 32'd1;
            if (stall && (stat_stalls_q != '1)) stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end
`else
    // Statistics counters are not built.
`endif
endmodule

// File: tb/tb_ram_port_dma.sv
// tb_ram_port_dma: directed + randomized bench for ram_port_dma with a 2-cycle RAM model
// and a flat reference memory holding what every completed write burst should have stored.
module tb_ram_port_dma;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int LW = 12;
    localparam int RL = 2;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_dma_if #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) bus ();

`ifdef RAM_DMA_STATS_EN
    logic [31:0] stat_beats, stat_stalls;
`endif

    ram_port_dma #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef RAM_DMA_STATS_EN
        ,
        .stat_beats_o  (stat_beats),
        .stat_stalls_o (stat_stalls)
`endif
    );

    // RAM model: one input register stage, then the array access -> data two cycles after ce.
    logic [DW-1:0] ram [0:4095] = '{default: '0};
    logic          s_ce = 1'b0, s_we = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_d = '0, q_r = '0;
    assign bus.ram_q = q_r;
    always @(posedge clk) begin
        s_ce <= bus.ram_ce; s_we <= bus.ram_we; s_addr <= bus.ram_addr; s_d <= bus.ram_d;
        if (s_ce && s_we)  ram[s_addr] <= s_d;
        if (s_ce && !s_we) q_r <= ram[s_addr];
    end

    logic [DW-1:0] ref_mem [0:4095] = '{default: '0};

    // Monitor: logs port activity at the falling edge.
    int            cyc_n = 0, done_n = 0, done_cyc = 0;
    logic [AW-1:0] acc_addr[$];
    logic          acc_we[$];
    logic [DW-1:0] acc_d[$];
    int            acc_cyc[$];
    int            vld_rise[$];
    logic [DW-1:0] pop_q[$];
    int            rvld_in_write = 0, stab_viol = 0, reads_tot = 0, pops_tot = 0, max_out = 0;
    logic          p_vld = 1'b0, p_rdy = 1'b0;
    logic [DW-1:0] p_data = '0;
    bit            in_write = 1'b0;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            reads_tot = pops_tot;
        end else begin
            if (bus.ram_ce) begin
                acc_addr.push_back(bus.ram_addr); acc_we.push_back(bus.ram_we);
                acc_d.push_back(bus.ram_d); acc_cyc.push_back(cyc_n);
                if (!bus.ram_we) reads_tot++;
            end
            if (bus.done) begin done_n++; done_cyc = cyc_n; end
            if (bus.rdata_valid && !p_vld) vld_rise.push_back(cyc_n);
            if (bus.rdata_valid && bus.rdata_ready) begin pop_q.push_back(bus.rdata); pops_tot++; end
            if (in_write && bus.rdata_valid) rvld_in_write++;
            if (p_vld && !p_rdy && (!bus.rdata_valid || bus.rdata !== p_data)) stab_viol++;
            if (reads_tot - pops_tot > max_out) max_out = reads_tot - pops_tot;
        end
        p_vld = bus.rdata_valid && !rst; p_rdy = bus.rdata_ready; p_data = bus.rdata;
    end

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input bit w, input int addr, input int len);
        int t = 0;
        while (!bus.cmd_ready && t < 50) begin cyc(); t++; end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = AW'(addr); bus.cmd_len = LW'(len);
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input int addr, input int len, input bit rnd, input logic [63:0] dbase);
        logic [DW-1:0] dat[$];
        int a0, d0, n, i, t, bad;
        bit hs;
        n = len + 1; a0 = acc_addr.size(); d0 = done_n;
        for (int k = 0; k < n; k++) dat.push_back(rnd ? {$urandom(), $urandom()} : dbase + 64'(k));
        in_write = 1'b1;
        send_cmd(1'b1, addr, len);
        i = 0; t = 0;
        while (i < n && t < n * 8 + 50) begin
            bus.wdata_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.wdata = dat[i];
            hs = bus.wdata_valid && bus.wdata_ready;
            cyc(); t++;
            if (hs) begin ref_mem[AW'(addr + i)] = dat[i]; i++; end
        end
        bus.wdata_valid = 1'b0;
        chk("wr_all_accepted", i, n);
        repeat (3) cyc();
        in_write = 1'b0;
        chk("wr_access_count", acc_addr.size() - a0, n);
        bad = 0;
        if (acc_addr.size() - a0 == n) begin
            for (int k = 0; k < n; k++)
                if (acc_addr[a0+k] !== AW'(addr + k) || acc_we[a0+k] !== 1'b1 || acc_d[a0+k] !== dat[k]) bad++;
            chk("wr_done_with_last", done_cyc, acc_cyc[a0+n-1]);
            if (!rnd) chk("wr_back_to_back", acc_cyc[a0+n-1] - acc_cyc[a0], n - 1);
        end else bad = n;
        chk("wr_beats", bad, 0);
        chk("wr_done_once", done_n - d0, 1);
    endtask

    task automatic do_read(input int addr, input int len, input int stall, input bit rnd, input bit lat);
        int a0, p0, d0, v0, n, t, bad;
        n = len + 1; a0 = acc_addr.size(); p0 = pop_q.size(); d0 = done_n; v0 = vld_rise.size();
        bus.rdata_ready = (stall == 0);
        send_cmd(1'b0, addr, len);
        t = 0;
        while (done_n == d0 && t < n * 10 + 100) begin
            if (stall > 0 && t == stall) begin
                chk("stall_reads_issued", acc_addr.size() - a0, FD);
                chk("stall_no_pops", pop_q.size() - p0, 0);
                chk("stall_fifo_valid", bus.rdata_valid, 1);
            end
            if (t < stall) bus.rdata_ready = 1'b0;
            else bus.rdata_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc(); t++;
        end
        bus.rdata_ready = 1'b0;
        repeat (2) cyc();
        chk("rd_done_once", done_n - d0, 1);
        chk("rd_issue_count", acc_addr.size() - a0, n);
        bad = 0;
        if (acc_addr.size() - a0 == n) begin
            for (int k = 0; k < n; k++)
                if (acc_we[a0+k] !== 1'b0 || acc_addr[a0+k] !== AW'(addr + k)) bad++;
        end else bad = n;
        chk("rd_addr_seq", bad, 0);
        chk("rd_pop_count", pop_q.size() - p0, n);
        bad = 0;
        if (pop_q.size() - p0 == n) begin
            for (int k = 0; k < n; k++) if (pop_q[p0+k] !== ref_mem[AW'(addr + k)]) bad++;
        end else bad = n;
        chk("rd_data", bad, 0);
        if (lat) chk("rd_first_latency", (vld_rise.size() > v0 && acc_addr.size() > a0) ?
                     vld_rise[v0] - acc_cyc[a0] : -1, 3);
    endtask

    initial begin
        int a1, d1, t, rc, addr;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wdata_valid = 0; bus.wdata = '0; bus.rdata_ready = 0;
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_wdata_ready", bus.wdata_ready, 0);
        chk("rst_rdata_valid", bus.rdata_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ram_ce", bus.ram_ce, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_d", bus.ram_d, 0);
        rst = 1'b0;
        cyc();

        do_write(12'h010, 3, 1'b0, 64'hA0);
        do_read(12'h010, 3, 0, 1'b0, 1'b1);
`ifdef RAM_DMA_STATS_EN
        chk("stat_beats", stat_beats, 8);
        chk("stat_stalls", stat_stalls, 0);
`endif
        do_read(12'h010, 3, 20, 1'b0, 1'b0);

        do_write(12'hFFF, 1, 1'b1, 64'h0);
        do_read(12'hFFF, 1, 0, 1'b0, 1'b0);

        // Reset in the cycle the third read of an 8-beat burst is on the RAM port.
        bus.rdata_ready = 1'b1;
        send_cmd(1'b0, 12'h100, 7);
        rc = 0; t = 0;
        while (rc < 3 && t < 30) begin cyc(); t++; if (bus.ram_ce) rc++; end
        chk("rst_mid_third_read", rc, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_ram_ce", bus.ram_ce, 0);
        chk("rst_mid_rdata_valid", bus.rdata_valid, 0);
        chk("rst_mid_cmd_ready", bus.cmd_ready, 1);
        a1 = acc_addr.size(); d1 = done_n;
        repeat (10) cyc();
        chk("rst_mid_no_done", done_n - d1, 0);
        chk("rst_mid_no_access", acc_addr.size() - a1, 0);
        bus.rdata_ready = 1'b0;
        do_read(12'h010, 3, 0, 1'b0, 1'b1);

        for (int it = 0; it < 14; it++) begin
            addr = $urandom_range(0, 4095);
            if (it % 2 == 0) do_write(addr, $urandom_range(0, 15), 1'b1, 64'h0);
            else do_read(addr, $urandom_range(0, 15), 0, 1'b1, 1'b0);
        end

        do_write($urandom_range(0, 4095), 4095, 1'b0, {$urandom(), $urandom()});
        do_read($urandom_range(0, 4095), 15, 0, 1'b1, 1'b0);

        chk("rdata_hold_when_stalled", stab_viol, 0);
        chk("no_rdata_valid_in_write", rvld_in_write, 0);
        chk("outstanding_le_depth", max_out <= FD, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
